// File: rtl/demux_sipo8.sv
// demux_sipo8: serial-in, parallel-out capture with a valid/ready word output.
// Each accepted bit is steered into the word position given by the write index SEL
// (LSB first). A finished word is held on Y until the consumer takes it. The serial
// side is stalled only on the last bit of a word, so an unconsumed Y is never overwritten.
module demux_sipo8 #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             clear,
    output logic [SEL_W-1:0] SEL,
    output logic [WIDTH-1:0] Y,
    output logic             y_valid,
    input  logic             y_ready
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(WIDTH - 1);

    // WIDTH must be a power of two so the index wraps naturally at WIDTH-1 -> 0
    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("demux_sipo8: WIDTH must be a power of two >= 2");
    end

    // Bits 0..WIDTH-2 of the word in progress; the top bit goes straight to Y
    logic [WIDTH-2:0] partial;

    logic at_last;
    logic accept;
    logic complete;

    // Handshake decode: stall only when the last bit would overwrite a pending word
    always_comb begin
        at_last   = (SEL == LAST_IDX);
        din_ready = !(at_last && y_valid && !y_ready);
        accept    = din_valid && din_ready && !clear;
        complete  = accept && at_last;
    end

    // Write index and partial word; clear aborts the word and drops the same-cycle bit
    always_ff @(posedge clk) begin
        if (rst) begin
            SEL     <= '0;
            partial <= '0;
        end else if (clear) begin
            SEL <= '0;
        end else if (accept) begin
            if (!at_last) begin
                partial[SEL] <= din;
            end
            SEL <= SEL + SEL_W'(1);
        end
    end

    // Output word register; a completion in the consume cycle keeps y_valid high
    always_ff @(posedge clk) begin
        if (rst) begin
            Y       <= '0;
            y_valid <= 1'b0;
        end else if (complete) begin
            Y       <= {din, partial};
            y_valid <= 1'b1;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux_sipo8.sv
// Directed bench for demux_sipo8: a queue-based word model checked every cycle,
// plus hand-computed literal checks at key points of each scenario.
module tb_demux_sipo8;

    localparam int unsigned WIDTH = 8;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       din_ready;
    logic       clear;
    logic [2:0] sel;
    logic [7:0] y;
    logic       y_valid;
    logic       y_ready;

    int errors = 0;
    int checks = 0;

    demux_sipo8 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .clear     (clear),
        .SEL       (sel),
        .Y         (y),
        .y_valid   (y_valid),
        .y_ready   (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bits accepted since last wrap/clear/reset, plus the pending output word
    logic       mbits[$];
    logic [7:0] my;
    logic       mv;
    logic       mstarted = 1'b0;
    logic       m_rdy;
    logic       m_done;
    logic [7:0] m_word;

    always @(posedge clk) begin
        if (rst) begin
            mbits.delete();
            my       = 8'h00;
            mv       = 1'b0;
            mstarted = 1'b1;
        end else if (mstarted) begin
            m_rdy  = !(mbits.size() == WIDTH - 1 && mv && !y_ready);
            m_done = 1'b0;
            m_word = 8'h00;
            if (clear) begin
                mbits.delete();
            end else if (din_valid && m_rdy) begin
                mbits.push_back(din);
                if (mbits.size() == WIDTH) begin
                    for (int i = 0; i < WIDTH; i++) m_word[i] = mbits[i];
                    mbits.delete();
                    m_done = 1'b1;
                end
            end
            if (m_done) begin
                my = m_word;
                mv = 1'b1;
            end else if (y_ready) begin
                mv = 1'b0;
            end
        end
    end

    // Per-cycle compare, mid-cycle while inputs and state are stable
    always @(negedge clk) begin
        if (mstarted) begin
            chk("model_sel", 32'(sel), 32'(mbits.size()));
            chk("model_y", 32'(y), 32'(my));
            chk("model_y_valid", 32'(y_valid), 32'(mv));
            chk("model_din_ready", 32'(din_ready),
                32'(!(mbits.size() == WIDTH - 1 && mv && !y_ready)));
        end
    end

    // Apply one cycle of inputs; returns just after the edge that sampled them
    task automatic tick(input logic d, input logic v, input logic c, input logic r);
        din       = d;
        din_valid = v;
        clear     = c;
        y_ready   = r;
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [7:0] w, input logic r);
        for (int i = 0; i < WIDTH; i++) tick(w[i], 1'b1, 1'b0, r);
    endtask

    logic [7:0] w;

    initial begin
        rst = 1'b1; din = 1'b1; din_valid = 1'b1; clear = 1'b0; y_ready = 1'b0;

        // Reset with active-looking inputs: nothing captured
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_y", 32'(y), 32'h00);
        chk("reset_y_valid", 32'(y_valid), 32'd0);
        chk("reset_din_ready", 32'(din_ready), 32'd1);
        rst = 1'b0;

        // Walking one, back-to-back words
        for (int k = 0; k < WIDTH; k++) begin
            w = 8'(8'h01 << k);
            send_word(w, 1'b1);
            chk("walk_y", 32'(y), 32'(w));
            chk("walk_y_valid", 32'(y_valid), 32'd1);
            chk("walk_sel_wrap", 32'(sel), 32'd0);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("walk_single_cycle", 32'(y_valid), 32'd0);

        // Backpressure on the last bit
        send_word(8'hA5, 1'b0);
        chk("bp_first_y", 32'(y), 32'hA5);
        w = 8'h3C;
        for (int i = 0; i < WIDTH - 1; i++) tick(w[i], 1'b1, 1'b0, 1'b0);
        tick(w[7], 1'b1, 1'b0, 1'b0);
        tick(w[7], 1'b1, 1'b0, 1'b0);
        chk("bp_stall_sel", 32'(sel), 32'd7);
        chk("bp_stall_ready", 32'(din_ready), 32'd0);
        chk("bp_hold_y", 32'(y), 32'hA5);
        tick(w[7], 1'b1, 1'b0, 1'b1);
        chk("bp_release_y", 32'(y), 32'h3C);
        chk("bp_release_valid", 32'(y_valid), 32'd1);
        chk("bp_release_sel", 32'(sel), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Valid gaps: SEL holds while din_valid is low
        w = 8'h5A;
        for (int i = 0; i < WIDTH; i++) begin
            for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                tick(~w[i], 1'b0, 1'b0, 1'b1);
                chk("gap_sel_hold", 32'(sel), 32'(i));
            end
            tick(w[i], 1'b1, 1'b0, 1'b1);
        end
        chk("gap_y", 32'(y), 32'h5A);

        // Clear mid-word drops the partial bits and the same-cycle bit
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_pre_sel", 32'(sel), 32'd3);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_sel", 32'(sel), 32'd0);
        send_word(8'hC3, 1'b1);
        chk("clr_word", 32'(y), 32'hC3);
        // Clear with a pending word leaves the output alone
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("clr_pend_y", 32'(y), 32'hC3);
        chk("clr_pend_valid", 32'(y_valid), 32'd1);
        chk("clr_pend_sel", 32'(sel), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-operation with a pending word
        send_word(8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("mid_pre_y", 32'(y), 32'hFF);
        chk("mid_pre_sel", 32'(sel), 32'd4);
        rst = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        chk("mid_rst_y", 32'(y), 32'h00);
        chk("mid_rst_valid", 32'(y_valid), 32'd0);
        chk("mid_rst_sel", 32'(sel), 32'd0);
        send_word(8'h96, 1'b1);
        chk("mid_after_y", 32'(y), 32'h96);
        chk("mid_after_valid", 32'(y_valid), 32'd1);

        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
